// File: rtl/stall_ctrl.sv
// Hazard/stall controller: combinational PC/F-D write-enables and D/E bubble, plus a mult/div busy sequencer.
// Hazard outputs have zero latency. The unit is busy for MULT_LAT/DIV_LAT cycles. Optional STALL_PERF_EN adds stall counters.
module stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic             ref_clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             branch_d,
    input  logic             muldiv_d,
    input  logic             is_div_d,
    input  logic             hilo_rd_d,
    input  logic             memread_e,
    input  logic             regwrite_e,
    input  logic [REG_W-1:0] writereg_e,
    input  logic             memread_m,
    input  logic [REG_W-1:0] writereg_m,
    output logic             we_pc,
    output logic             we_fd,
    output logic             flush_de,
    output logic             muldiv_busy,
    output logic             muldiv_done
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      md_stall_cycles
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] w_lat_m1;
    logic             w_e_hit, w_m_hit;
    logic             w_lu, w_br_e, w_br_m, w_md, w_stall, w_done, w_accept;

    assign w_e_hit = (writereg_e != '0) && ((writereg_e == rs_d) || (writereg_e == rt_d));
    assign w_m_hit = (writereg_m != '0) && ((writereg_m == rs_d) || (writereg_m == rt_d));

    assign w_lu    = memread_e && w_e_hit;
    assign w_br_e  = branch_d && regwrite_e && w_e_hit;
    assign w_br_m  = branch_d && memread_m && w_m_hit;

    assign muldiv_busy = (r_state == BUSY);
    assign w_done      = muldiv_busy && (r_count == '0);
    assign muldiv_done = w_done;

    // The done cycle releases dependants so a waiting HI/LO read or mult/div issues without a bubble.
    assign w_md    = (hilo_rd_d || muldiv_d) && muldiv_busy && !w_done;
    assign w_stall = w_lu || w_br_e || w_br_m || w_md;

    assign we_pc    = !w_stall || !rst_n;
    assign we_fd    = !w_stall || !rst_n;
    assign flush_de = w_stall && rst_n;

    assign w_accept = muldiv_d && !w_stall;
    assign w_lat_m1 = is_div_d ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUSY;
                    w_count_nxt = w_lat_m1;
                end
            end
            BUSY: begin
                if (w_done) begin
                    if (w_accept) begin
                        w_state_nxt = BUSY;
                        w_count_nxt = w_lat_m1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] r_stall_cycles, r_md_stall_cycles;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles    <= '0;
            r_md_stall_cycles <= '0;
        end else begin
            if (w_stall) r_stall_cycles    <= r_stall_cycles + 32'd1;
            if (w_md)    r_md_stall_cycles <= r_md_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign md_stall_cycles = r_md_stall_cycles;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl with defaults MULT_LAT=4, DIV_LAT=32.
// Observed vector order: {we_pc, we_fd, flush_de, muldiv_busy, muldiv_done}.
module tb_stall_ctrl;

    logic       ref_clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_d, rt_d, writereg_e, writereg_m;
    logic       branch_d, muldiv_d, is_div_d, hilo_rd_d;
    logic       memread_e, regwrite_e, memread_m;
    logic       we_pc, we_fd, flush_de, muldiv_busy, muldiv_done;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles, md_stall_cycles;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [4:0] obs;
    assign obs = {we_pc, we_fd, flush_de, muldiv_busy, muldiv_done};

    always #5 ref_clk = ~ref_clk;

    stall_ctrl dut (
        .ref_clk    (ref_clk),
        .rst_n      (rst_n),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .branch_d   (branch_d),
        .muldiv_d   (muldiv_d),
        .is_div_d   (is_div_d),
        .hilo_rd_d  (hilo_rd_d),
        .memread_e  (memread_e),
        .regwrite_e (regwrite_e),
        .writereg_e (writereg_e),
        .memread_m  (memread_m),
        .writereg_m (writereg_m),
        .we_pc      (we_pc),
        .we_fd      (we_fd),
        .flush_de   (flush_de),
        .muldiv_busy(muldiv_busy),
        .muldiv_done(muldiv_done)
`ifdef STALL_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .md_stall_cycles(md_stall_cycles)
`endif
    );

    task automatic clear_inputs();
        rs_d = '0; rt_d = '0; writereg_e = '0; writereg_m = '0;
        branch_d = 0; muldiv_d = 0; is_div_d = 0; hilo_rd_d = 0;
        memread_e = 0; regwrite_e = 0; memread_m = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        memread_e = 1; writereg_e = 5'd8; rs_d = 5'd8; hilo_rd_d = 1;
        #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL reset_forced: got %b want %b", obs, 5'b11000);
        else n_pass++;
        @(negedge ref_clk);
        @(negedge ref_clk);
        clear_inputs();
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL reset_release: got %b want %b", obs, 5'b11000);
        else n_pass++;
    endtask

    task automatic test_load_use();
        @(negedge ref_clk);
        memread_e = 1; writereg_e = 5'd8; rs_d = 5'd8; #1;
        n_chk++;
        if (obs !== 5'b00100) $display("FAIL load_use_stall: got %b want %b", obs, 5'b00100);
        else n_pass++;
        @(negedge ref_clk);
        memread_e = 0; #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL load_use_clear: got %b want %b", obs, 5'b11000);
        else n_pass++;
        @(negedge ref_clk);
        clear_inputs(); memread_e = 1; writereg_e = 5'd12; rt_d = 5'd12; rs_d = 5'd3; #1;
        n_chk++;
        if (obs !== 5'b00100) $display("FAIL load_use_rt: got %b want %b", obs, 5'b00100);
        else n_pass++;
        @(negedge ref_clk);
        clear_inputs(); memread_e = 1; writereg_e = 5'd0; rs_d = 5'd0; #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL reg_zero_guard: got %b want %b", obs, 5'b11000);
        else n_pass++;
        @(negedge ref_clk);
        clear_inputs(); memread_e = 1; writereg_e = 5'd7; rs_d = 5'd6; rt_d = 5'd5; #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL load_no_match: got %b want %b", obs, 5'b11000);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_branch();
        int stalls;
        stalls = 0;
        @(negedge ref_clk);
        branch_d = 1; rt_d = 5'd9; memread_e = 1; regwrite_e = 1; writereg_e = 5'd9; #1;
        if (flush_de) stalls++;
        @(negedge ref_clk);
        memread_e = 0; regwrite_e = 0; writereg_e = 5'd0; memread_m = 1; writereg_m = 5'd9; #1;
        if (flush_de) stalls++;
        @(negedge ref_clk);
        memread_m = 0; writereg_m = 5'd0; #1;
        n_chk++;
        if (stalls !== 2) $display("FAIL branch_load_stalls: got %0d want 2", stalls);
        else n_pass++;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL branch_load_release: got %b want %b", obs, 5'b11000);
        else n_pass++;
        @(negedge ref_clk);
        clear_inputs(); branch_d = 1; rs_d = 5'd5; regwrite_e = 1; writereg_e = 5'd5; #1;
        n_chk++;
        if (obs !== 5'b00100) $display("FAIL branch_alu_stall: got %b want %b", obs, 5'b00100);
        else n_pass++;
        @(negedge ref_clk);
        clear_inputs(); regwrite_e = 1; writereg_e = 5'd5; rs_d = 5'd5; #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL nonbranch_alu_no_stall: got %b want %b", obs, 5'b11000);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_multiply();
        logic [4:0] exp;
        @(negedge ref_clk);
        hilo_rd_d = 1; #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL hilo_idle: got %b want %b", obs, 5'b11000);
        else n_pass++;
        hilo_rd_d = 0; muldiv_d = 1; is_div_d = 0; #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL mult_issue: got %b want %b", obs, 5'b11000);
        else n_pass++;
        for (int k = 1; k <= 5; k++) begin
            @(negedge ref_clk);
            muldiv_d = 0; hilo_rd_d = 1; #1;
            exp = (k < 4) ? 5'b00110 : (k == 4) ? 5'b11011 : 5'b11000;
            n_chk++;
            if (obs !== exp) $display("FAIL mult_cycle%0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_blocked_muldiv();
        @(negedge ref_clk);
        muldiv_d = 1; memread_e = 1; writereg_e = 5'd3; rs_d = 5'd3; #1;
        n_chk++;
        if (obs !== 5'b00100) $display("FAIL muldiv_blocked_stall: got %b want %b", obs, 5'b00100);
        else n_pass++;
        @(negedge ref_clk);
        clear_inputs(); #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL muldiv_blocked_not_started: got %b want %b", obs, 5'b11000);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        int busy_n, done_n;
        busy_n = 0; done_n = 0;
        @(negedge ref_clk);
        muldiv_d = 1; is_div_d = 1; #1;
        for (int k = 1; k <= 65; k++) begin
            @(negedge ref_clk);
            muldiv_d = (k <= 32); #1;
            if (k == 32 || k == 64) exp = 5'b11011;
            else if (k < 32)        exp = 5'b00110;
            else if (k < 64)        exp = 5'b11010;
            else                    exp = 5'b11000;
            if (muldiv_busy) busy_n++;
            if (muldiv_done) done_n++;
            n_chk++;
            if (obs !== exp) $display("FAIL div_b2b_cycle%0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        n_chk++;
        if (busy_n !== 64) $display("FAIL div_b2b_busy_count: got %0d want 64", busy_n);
        else n_pass++;
        n_chk++;
        if (done_n !== 2) $display("FAIL div_b2b_done_count: got %0d want 2", done_n);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_reset_mid_div();
        int done_n;
        done_n = 0;
        @(negedge ref_clk);
        muldiv_d = 1; is_div_d = 1; #1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge ref_clk);
            muldiv_d = 0; #1;
        end
        n_chk++;
        if (obs !== 5'b11010) $display("FAIL div_busy_c10: got %b want %b", obs, 5'b11010);
        else n_pass++;
        #1;
        memread_e = 1; writereg_e = 5'd4; rs_d = 5'd4; hilo_rd_d = 1;
        rst_n = 1'b0; #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL mid_reset_immediate: got %b want %b", obs, 5'b11000);
        else n_pass++;
        @(posedge ref_clk); #1;
        n_chk++;
        if (obs !== 5'b11000) $display("FAIL mid_reset_held: got %b want %b", obs, 5'b11000);
        else n_pass++;
`ifdef STALL_PERF_EN
        n_chk++;
        if (stall_cycles !== 32'd0) $display("FAIL perf_reset: got %0d want 0", stall_cycles);
        else n_pass++;
`endif
        @(negedge ref_clk);
        clear_inputs(); rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge ref_clk); #1;
            if (muldiv_done || muldiv_busy) done_n++;
        end
        n_chk++;
        if (done_n !== 0) $display("FAIL mid_reset_no_done: got %0d busy/done cycles want 0", done_n);
        else n_pass++;
`ifdef STALL_PERF_EN
        @(negedge ref_clk);
        memread_e = 1; writereg_e = 5'd4; rs_d = 5'd4;
        @(negedge ref_clk);
        clear_inputs(); #1;
        n_chk++;
        if (stall_cycles !== 32'd1) $display("FAIL perf_count: got %0d want 1", stall_cycles);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_multiply();
        test_blocked_muldiv();
        test_back_to_back();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
